// File: rtl/spi_master_ms.sv
// spi_master_ms: multi-slave SPI master covering all four SPI modes,
// selectable bit order, programmable SCLK rate and back-to-back words
// with the slave select held low between them.
module spi_master_ms #(
    parameter int SLAVES  = 4,
    parameter int D_WIDTH = 8,
    parameter int ADDR_W  = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               lsb_first,
    input  logic               cont,
    input  logic [7:0]         clk_div,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [D_WIDTH-1:0] tx_data,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic [SLAVES-1:0]  ss_n,
    output logic               busy,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               tx_load,
    output logic               addr_err
);
    localparam int BW = $clog2(D_WIDTH);
    localparam int EW = BW + 1;
    localparam logic [EW-1:0]     LAST_EDGE = EW'(2 * D_WIDTH - 1);
    localparam logic [BW-1:0]     LAST_BIT  = BW'(D_WIDTH - 1);
    localparam logic [ADDR_W:0]   NSLV      = SLAVES[ADDR_W:0];

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t             state;
    logic               cpol_q, cpha_q, lsb_q;
    logic [7:0]         div_q, half_cnt;
    logic [EW-1:0]      edge_cnt;
    logic [D_WIDTH-1:0] tx_q, rx_sr, rx_next;
    logic [BW-1:0]      bit_idx, nxt_idx;
    logic               leading, half_done, last_edge, sample_now;

    // Word position of the i-th bit on the wire for the chosen bit order.
    function automatic logic [BW-1:0] bit_pos(input logic [BW-1:0] idx, input logic lsb);
        return lsb ? idx : LAST_BIT - idx;
    endfunction

    // Edge bookkeeping: edge_cnt counts SCLK edges within the current word,
    // even counts are leading edges, edge_cnt/2 is the bit on the wire.
    always_comb begin
        bit_idx    = edge_cnt[EW-1:1];
        nxt_idx    = bit_idx + 1'b1;
        leading    = ~edge_cnt[0];
        half_done  = (half_cnt == div_q - 8'd1);
        last_edge  = (edge_cnt == LAST_EDGE);
        sample_now = half_done & (leading ^ cpha_q);
        rx_next    = rx_sr;
        rx_next[bit_pos(bit_idx, lsb_q)] = miso;
    end

    // Transfer FSM with registered SPI pins and status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            addr_err <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            div_q    <= '0;
            half_cnt <= '0;
            edge_cnt <= '0;
            tx_q     <= '0;
            rx_sr    <= '0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    sclk     <= cpol;
                    mosi     <= 1'b0;
                    ss_n     <= '1;
                    busy     <= 1'b0;
                    half_cnt <= '0;
                    edge_cnt <= '0;
                    if (enable) begin
                        if ({1'b0, addr} < NSLV) begin
                            state   <= SHIFT;
                            cpol_q  <= cpol;
                            cpha_q  <= cpha;
                            lsb_q   <= lsb_first;
                            div_q   <= (clk_div == 8'd0) ? 8'd1 : clk_div;
                            tx_q    <= tx_data;
                            tx_load <= 1'b1;
                            ss_n    <= ~(SLAVES'(1) << addr);
                            busy    <= 1'b1;
                            mosi    <= cpha ? 1'b0
                                            : (lsb_first ? tx_data[0] : tx_data[D_WIDTH-1]);
                        end else begin
                            addr_err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (!half_done) begin
                        half_cnt <= half_cnt + 8'd1;
                    end else begin
                        half_cnt <= '0;
                        sclk     <= ~sclk;
                        if (sample_now) begin
                            rx_sr <= rx_next;
                            if (bit_idx == LAST_BIT) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                            end
                        end
                        if (leading && cpha_q)
                            mosi <= tx_q[bit_pos(bit_idx, lsb_q)];
                        if (last_edge) begin
                            edge_cnt <= '0;
                            sclk     <= cpol_q;
                            if (cont) begin
                                tx_q    <= tx_data;
                                tx_load <= 1'b1;
                                if (!cpha_q)
                                    mosi <= lsb_q ? tx_data[0] : tx_data[D_WIDTH-1];
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                            if (!leading && !cpha_q)
                                mosi <= tx_q[bit_pos(nxt_idx, lsb_q)];
                        end
                    end
                end
                HOLD: begin
                    if (half_done) begin
                        state    <= IDLE;
                        ss_n     <= '1;
                        busy     <= 1'b0;
                        mosi     <= 1'b0;
                        half_cnt <= '0;
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ms.sv
// Bench for spi_master_ms: directed and random transfers observed at the
// pins and checked against a bus-level slave model and per-word expectations.
module tb_spi_master_ms;
    localparam int D = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         enable = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, cont = 1'b0;
    logic [7:0]   clk_div = 8'd2;
    logic [1:0]   addr = 2'd0;
    logic [D-1:0] tx_data = '0;
    logic         miso;
    logic         sclk, mosi, busy, rx_valid, tx_load, addr_err;
    logic [3:0]   ss_n;
    logic [D-1:0] rx_data;

    logic         enable3 = 1'b0;
    logic [1:0]   addr3 = 2'd0;
    logic         sclk3, mosi3, busy3, rxv3, txl3, aerr3;
    logic [2:0]   ss3_n;
    logic [D-1:0] rx3;

    logic loop = 1'b0, sl_bit = 1'b0;
    assign miso = loop ? mosi : sl_bit;

    spi_master_ms #(.SLAVES(4), .D_WIDTH(D), .ADDR_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cont(cont), .clk_div(clk_div), .addr(addr),
        .tx_data(tx_data), .miso(miso), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid), .tx_load(tx_load),
        .addr_err(addr_err)
    );

    spi_master_ms #(.SLAVES(3), .D_WIDTH(D), .ADDR_W(2)) dut3 (
        .clock(clock), .reset_n(reset_n), .enable(enable3), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cont(1'b0), .clk_div(clk_div), .addr(addr3),
        .tx_data(tx_data), .miso(1'b0), .sclk(sclk3), .mosi(mosi3), .ss_n(ss3_n),
        .busy(busy3), .rx_data(rx3), .rx_valid(rxv3), .tx_load(txl3),
        .addr_err(aerr3)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference state for the transfer in flight
    logic [D-1:0] m_tx[4], m_rx[4], fix_tx[3];
    bit           use_fix = 0;
    int           m_nw;
    logic         m_cpha, m_lsb;
    logic [3:0]   m_mask;

    // Pin observations
    bit           mon_on = 0;
    int           cyc, n_edges, n_load, g, last_edge, sp_min, sp_max, sel_bad, n_aerr;
    logic [D-1:0] rxq[$];
    logic         mosiq[$];
    logic         prev_sclk;
    logic [3:0]   prev_ss;

    // Slave response: global bit g across the word stream, in the selected order.
    function automatic logic slave_bit(input int gi);
        if (gi >= m_nw * D) return 1'b0;
        return m_rx[gi / D][m_lsb ? gi % D : D - 1 - gi % D];
    endfunction

    // Pin monitor plus slave model and tx_data/cont feeder.
    always @(negedge clock) begin
        bit lead;
        if (mon_on) begin
            cyc++;
            if (addr_err) n_aerr++;
            if (busy ? (ss_n !== ~m_mask) : (ss_n !== 4'hF)) sel_bad++;
            if (tx_load) begin
                n_load++;
                if (n_load < m_nw) tx_data = m_tx[n_load];
                if (n_load >= m_nw) cont = 1'b0;
            end
            if (rx_valid) rxq.push_back(rx_data);
            if (prev_ss == 4'hF && ss_n != 4'hF) begin
                last_edge = cyc;
                g = 0;
                if (!m_cpha) sl_bit = slave_bit(0);
            end
            if (sclk !== prev_sclk && ss_n != 4'hF) begin
                lead = (n_edges % 2 == 0);
                if (cyc - last_edge < sp_min) sp_min = cyc - last_edge;
                if (cyc - last_edge > sp_max) sp_max = cyc - last_edge;
                last_edge = cyc;
                if (lead != m_cpha) mosiq.push_back(mosi);
                if (!m_cpha && !lead) begin g++; sl_bit = slave_bit(g); end
                if (m_cpha && lead) begin sl_bit = slave_bit(g); g++; end
                n_edges++;
            end
            prev_sclk = sclk;
            prev_ss   = ss_n;
        end
    end

    task automatic start_xfer(input logic [1:0] a, input logic pol, input logic pha,
                              input logic lsb, input logic [7:0] div, input int nw,
                              input logic lp, input logic ones, input string tag);
        m_nw = nw; m_cpha = pha; m_lsb = lsb; m_mask = 4'(1) << a;
        for (int i = 0; i < 4; i++) begin
            m_tx[i] = (use_fix && i < 3) ? fix_tx[i] : D'($urandom);
            m_rx[i] = ones ? '1 : D'($urandom);
        end
        loop = lp; sl_bit = 1'b0;
        @(negedge clock);
        addr = a; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div;
        tx_data = m_tx[0]; cont = (nw > 1);
        repeat (2) @(negedge clock);
        chk({tag, ":idle_sclk"}, sclk, pol);
        rxq.delete(); mosiq.delete();
        cyc = 0; n_edges = 0; n_load = 0; g = 0; sp_min = 1000; sp_max = 0;
        sel_bad = 0; n_aerr = 0;
        prev_sclk = sclk; prev_ss = ss_n;
        mon_on = 1;
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        // inputs wander while busy; the transfer must not notice
        cpol = 1'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom);
        clk_div = 8'($urandom); addr = 2'($urandom); enable = 1'b0;
    endtask

    task automatic do_xfer(input logic [1:0] a, input logic pol, input logic pha,
                           input logic lsb, input logic [7:0] div, input int nw,
                           input logic lp, input logic ones, input string tag);
        int dv, budget, k;
        logic [D-1:0] got;
        dv = (div == 8'd0) ? 1 : int'(div);
        start_xfer(a, pol, pha, lsb, div, nw, lp, ones, tag);
        budget = (2 * D * nw + 8) * dv + 20;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk({tag, ":done"}, (k < budget), 1'b1);
        chk({tag, ":end_sclk"}, sclk, pol);
        chk({tag, ":end_ss"}, ss_n, 4'hF);
        @(negedge clock);
        mon_on = 0;
        chk({tag, ":tx_load"}, n_load, nw);
        chk({tag, ":rx_valid"}, rxq.size(), nw);
        chk({tag, ":edges"}, n_edges, 2 * D * nw);
        chk({tag, ":gap_min"}, sp_min, dv);
        chk({tag, ":gap_max"}, sp_max, dv);
        chk({tag, ":select"}, sel_bad, 0);
        chk({tag, ":addr_err"}, n_aerr, 0);
        chk({tag, ":mosi_bits"}, mosiq.size(), D * nw);
        if (mosiq.size() == D * nw) begin
            for (int w = 0; w < nw; w++) begin
                got = '0;
                for (int i = 0; i < D; i++) got[lsb ? i : D - 1 - i] = mosiq[w * D + i];
                chk({tag, ":mosi_word"}, got, m_tx[w]);
            end
        end
        if (rxq.size() == nw) begin
            for (int w = 0; w < nw; w++)
                chk({tag, ":rx_word"}, rxq[w], lp ? m_tx[w] : m_rx[w]);
        end
        use_fix = 0;
    endtask

    initial begin
        int k;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst:sclk", sclk, 1'b0);
        chk("rst:mosi", mosi, 1'b0);
        chk("rst:ss_n", ss_n, 4'hF);
        chk("rst:busy", busy, 1'b0);
        chk("rst:rx_data", rx_data, '0);
        chk("rst:pulses", {rx_valid, tx_load, addr_err}, 3'b000);
        chk("rst:ss3", ss3_n, 3'b111);
        reset_n = 1'b1;

        // mode 0, MSB first, loopback of 0xA5 to slave 1
        fix_tx[0] = 8'hA5; use_fix = 1;
        do_xfer(2'd1, 1'b0, 1'b0, 1'b0, 8'd2, 1, 1'b1, 1'b0, "loop_a5");
        // mode 3, LSB first, 0x3C out, miso held high
        fix_tx[0] = 8'h3C; use_fix = 1;
        do_xfer(2'd2, 1'b1, 1'b1, 1'b1, 8'd2, 1, 1'b0, 1'b1, "mode3_3c");
        // three continued words with select held
        fix_tx[0] = 8'h11; fix_tx[1] = 8'h22; fix_tx[2] = 8'h33; use_fix = 1;
        do_xfer(2'd0, 1'b0, 1'b0, 1'b0, 8'd2, 3, 1'b1, 1'b0, "cont3");
        // divider 0 behaves as divider 1
        do_xfer(2'd3, 1'b0, 1'b1, 1'b0, 8'd0, 2, 1'b0, 1'b0, "div0");
        do_xfer(2'd3, 1'b1, 1'b0, 1'b1, 8'd1, 2, 1'b0, 1'b0, "div1");

        // address range on a three-slave master
        @(negedge clock);
        clk_div = 8'd1; addr3 = 2'd3; enable3 = 1'b1;
        @(negedge clock);
        enable3 = 1'b0;
        chk("aerr:pulse", aerr3, 1'b1);
        chk("aerr:busy", busy3, 1'b0);
        chk("aerr:ss", ss3_n, 3'b111);
        @(negedge clock);
        chk("aerr:one_cycle", aerr3, 1'b0);
        chk("aerr:still_idle", busy3, 1'b0);
        addr3 = 2'd2; enable3 = 1'b1;
        @(negedge clock);
        enable3 = 1'b0;
        chk("aerr:top_ok", {aerr3, busy3, ss3_n}, 5'b0_1_011);
        k = 0;
        while (busy3 !== 1'b0 && k < 200) begin @(negedge clock); k++; end
        chk("aerr:top_done", (k < 200), 1'b1);

        // reset in the middle of a word
        start_xfer(2'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1, 1'b0, 1'b0, "midrst");
        k = 0;
        while (n_edges < 7 && k < 100) begin @(negedge clock); #2; k++; end
        chk("midrst:reach7", (k < 100), 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst:ss_n", ss_n, 4'hF);
        chk("midrst:busy", busy, 1'b0);
        chk("midrst:pins", {sclk, mosi}, 2'b00);
        chk("midrst:rx_data", rx_data, '0);
        repeat (2) @(negedge clock);
        mon_on = 0;
        chk("midrst:no_rxv", rxq.size(), 0);
        reset_n = 1'b1;
        do_xfer(2'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1, 1'b0, 1'b0, "after_rst");

        // random modes, orders, dividers, word counts, and data sources
        for (int t = 0; t < 12; t++) begin
            do_xfer(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom_range(0, 4)), int'($urandom_range(1, 3)),
                    1'($urandom), 1'b0, $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
